// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 register file and exception/interrupt responder for the M stage.
// Req is combinational; SR/Cause/EPC update on the following rising edge.
`timescale 1ns/1ps
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] WPC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic        Mtc0_M,
  input  logic        Mfc0_M,
  input  logic        Eret_M,
  input  logic [4:0]  RegRd_M,
  input  logic [31:0] RFD2_M,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] handler_pc,
  output logic [31:0] cp0_rdata,
  output logic [31:0] EPC_out
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_pc;
  logic [31:0] sr_view;
  logic [31:0] cause_view;

  // Req is masked by reset so a pending request drops the moment reset rises.
  always_comb begin
    int_req = sr_ie_q & ~sr_exl_q & (|(HWInt & sr_im_q));
    exc_req = ~sr_exl_q & (ExcCode_M != 5'd0);
    Req     = ~reset & (int_req | exc_req);
  end

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = HWInt;
    victim_pc   = BD_M ? (WPC_M - 32'd4) : WPC_M;
    if (Req) begin
      // The M instruction is aborted: its mtc0/eret side effects are discarded.
      sr_exl_d    = 1'b1;
      cause_bd_d  = BD_M;
      cause_exc_d = int_req ? 5'd0 : ExcCode_M;
      epc_d       = {victim_pc[31:2], 2'b00};
    end else begin
      if (Mtc0_M && (RegRd_M == REG_SR)) begin
        sr_im_d  = RFD2_M[15:10];
        sr_exl_d = RFD2_M[1];
        sr_ie_d  = RFD2_M[0];
      end
      if (Mtc0_M && (RegRd_M == REG_EPC)) begin
        epc_d = {RFD2_M[31:2], 2'b00};
      end
      if (Eret_M) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    sr_view    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    cause_view = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'b00};
    cp0_rdata  = 32'd0;
    if (Mfc0_M) begin
      case (RegRd_M)
        REG_SR:    cp0_rdata = sr_view;
        REG_CAUSE: cp0_rdata = cause_view;
        REG_EPC:   cp0_rdata = epc_q;
        REG_PRID:  cp0_rdata = PRID_VAL;
        default:   cp0_rdata = 32'd0;
      endcase
    end
  end

  assign handler_pc = HANDLER_ADDR;
  assign EPC_out    = epc_q;

endmodule
